// File: rtl/free_list_ctrl.sv
// free_list_ctrl: physical-register free list for the rename stage.
// Circular buffer of free tags with head (next grant), tail (next release slot)
// and an occupancy counter. One alloc and one release per cycle, plus a flush
// rollback that moves head back over the most recent allocations.
// Ports:
//   CLK, RESET          clock, async active-low reset
//   alloc_req           rename wants a destination tag
//   alloc_ready         list non-empty (rename stalls when low)
//   alloc_tag           tag at head, granted on an accepted alloc
//   rel_valid/rel_tag   commit returns a tag
//   rb_valid/rb_num     undo the rb_num most recent allocations
//   free_count          current number of free tags
//   err                 sticky protocol-violation flag
module free_list_ctrl #(
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned NUM_ARCH = 32,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned CNT_W    = 7
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             rel_valid,
  input  logic [TAG_W-1:0] rel_tag,
  input  logic             rb_valid,
  input  logic [CNT_W-1:0] rb_num,
  output logic [CNT_W-1:0] free_count,
  output logic             err
);

  localparam int unsigned MAX_FREE = NUM_PHYS - NUM_ARCH;
  // One extra bit so count + rb_num + 1 cannot overflow before the limit check.
  localparam int unsigned SUM_W    = CNT_W + 1;

  logic [TAG_W-1:0] r_mem [NUM_PHYS];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic             w_alloc_acc;
  logic             w_rb_ok;
  logic             w_rel_ok;
  logic             w_err_set;
  logic [SUM_W-1:0] w_rb_sum;
  logic [SUM_W-1:0] w_rel_sum;
  logic [CNT_W-1:0] w_count_nxt;
  logic [TAG_W-1:0] w_head_nxt;
  logic [TAG_W-1:0] w_tail_nxt;

  // Accept/drop decisions and next pointer/count values.
  always_comb begin
    w_alloc_acc = alloc_req && (r_count != '0) && !rb_valid;

    // Rollback legality already accounts for a same-cycle release.
    w_rb_sum = SUM_W'(r_count) + SUM_W'(rb_num) + SUM_W'(rel_valid);
    w_rb_ok  = rb_valid && (w_rb_sum <= SUM_W'(MAX_FREE));

    // Release is judged on the post-cycle count, including an accepted rollback.
    w_rel_sum = SUM_W'(r_count) - SUM_W'(w_alloc_acc) + SUM_W'(1'b1)
              + (w_rb_ok ? SUM_W'(rb_num) : '0);
    w_rel_ok  = rel_valid && (w_rel_sum <= SUM_W'(MAX_FREE));

    w_err_set = (rb_valid && !w_rb_ok) || (rel_valid && !w_rel_ok);

    w_count_nxt = r_count - CNT_W'(w_alloc_acc) + CNT_W'(w_rel_ok)
                + (w_rb_ok ? rb_num : '0);
    w_head_nxt  = r_head + TAG_W'(w_alloc_acc)
                - (w_rb_ok ? TAG_W'(rb_num) : '0);
    w_tail_nxt  = r_tail + TAG_W'(w_rel_ok);
  end

  // Tag storage; reset preloads the tags above the architectural mapping.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < NUM_PHYS; i++) begin
        r_mem[i] <= (i < MAX_FREE) ? TAG_W'(NUM_ARCH + i) : '0;
      end
    end else if (w_rel_ok) begin
      r_mem[r_tail] <= rel_tag;
    end
  end

  // Pointers, occupancy and sticky error.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_head  <= '0;
      r_tail  <= TAG_W'(MAX_FREE);
      r_count <= CNT_W'(MAX_FREE);
      r_err   <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign alloc_ready = (r_count != '0);
  assign alloc_tag   = r_mem[r_head];
  assign free_count  = r_count;
  assign err         = r_err;

endmodule

// File: doc/free_list_ctrl.md
Name: free_list_ctrl

Overview:
- Owns and sequences the physical-register free list for the rename stage.
- Hands out one free physical tag per cycle to rename and accepts one released tag per cycle from commit/retire.
- Supports a rollback that returns the most recent N allocations on a pipeline flush.
- Implemented as a circular buffer with head/tail pointers and an occupancy counter; drives the rename-stage stall.

Parameters:
- NUM_PHYS, 64, number of physical registers; power of 2; also the buffer depth.
- NUM_ARCH, 32, number of architectural registers; mapped to phys 0..NUM_ARCH-1 at reset.
- TAG_W, 6, physical tag width, log2(NUM_PHYS).
- CNT_W, 7, counter width, log2(NUM_PHYS)+1.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- alloc_req  in  1  rename wants a destination tag this cycle.
- alloc_ready  out  1  free list non-empty; when 0, rename stalls.
- alloc_tag  out  TAG_W  tag granted on an accepted alloc; equals mem[head].
- rel_valid  in  1  commit releases rel_tag this cycle.
- rel_tag  in  TAG_W  tag being returned to the free list.
- rb_valid  in  1  flush rollback request.
- rb_num  in  CNT_W  number of most recent allocations to undo.
- free_count  out  CNT_W  current number of free tags.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- MAX_FREE = NUM_PHYS - NUM_ARCH. Pointers wrap modulo NUM_PHYS.
- Reset (async, RESET=0), all outputs registered or derived from state:
  - mem[i] = NUM_ARCH+i for i < MAX_FREE; remaining entries = 0.
  - head = 0, tail = MAX_FREE, count = MAX_FREE, err = 0.
  - Resulting output values: alloc_tag = NUM_ARCH (32), alloc_ready = 1, free_count = 32.
- Combinational outputs:
  - alloc_ready = (count != 0).
  - alloc_tag = mem[head].
  - free_count = count.
  - No same-cycle bypass from rel_tag to alloc_tag.
- Accepted alloc: alloc_req & alloc_ready & !rb_valid. Effect at posedge: head += 1, count -= 1. The tag is valid for rename in the same cycle alloc_req is high.
- Alloc with count == 0: no state change; alloc_tag is don't-care.
- Release: rel_valid writes mem[tail] = rel_tag, then tail += 1, count += 1.
  - If the post-cycle count would exceed MAX_FREE, the release is dropped and err is set.
- Rollback: rb_valid sets head -= rb_num and count += rb_num.
  - Undone tags are still stored behind head and are never overwritten, since at most MAX_FREE tags are outstanding.
  - rb_valid overrides alloc_req in the same cycle; the alloc is not accepted.
  - If count + rb_num (+1 if rel_valid) > MAX_FREE, the rollback is ignored and err is set; any release in that cycle is still processed under the release rule.
  - rb_num = 0 is a no-op.
- Simultaneous events:
  - Alloc + release: head and tail both advance; count unchanged.
  - Release + rollback: both apply; count += rb_num + 1.
  - Release into an empty list: alloc_ready rises on the next cycle.
  - Alloc + release at count == MAX_FREE: legal; count unchanged.
- err is sticky; it clears only on reset.
- Reset asserted mid-operation: everything returns immediately to the reset state; in-flight requests are discarded.
- No checks for duplicate tags (verification asserts this externally).

Test Plan:
- Reset release -> alloc_tag = 32, free_count = 32, alloc_ready = 1, err = 0.
- alloc_req held 32 cycles, no releases -> tags 32..63 granted in order; free_count reaches 0; alloc_ready = 0; a 33rd request leaves state unchanged.
- From empty, rel_valid with rel_tag = 5, then alloc_req next cycle -> alloc_ready = 1 one cycle after the release; alloc_tag = 5; free_count returns 1 -> 0.
- Alloc 3 tags (32, 33, 34), then rb_valid with rb_num = 3 and alloc_req high in the same cycle -> no grant that cycle; free_count = 32; next grant is 32.
- At free_count = 32, rel_valid alone -> dropped, err = 1, free_count stays 32. Same with alloc_req high -> accepted, count stays 32, err unchanged.
- Pointer wrap: 100 cycles of alloc+release with rotating tags -> FIFO order preserved across the wrap at index 63 -> 0; free_count constant.
